// File: rtl/multiword_subtract_pkg.sv
// Shared constants for the multiword subtract sequencer: default slice sizing and
// the FSM state encoding.
package multiword_subtract_pkg;

    localparam int unsigned DEFAULT_WORD  = 4;
    localparam int unsigned DEFAULT_WORDS = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

endpackage

// File: rtl/ripple_carry_subtractor.sv
// Combinational N-bit ripple-borrow subtractor: diff = a - b - bin, bout = borrow out.
module ripple_carry_subtractor #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         bin_i,
    output logic [N-1:0] diff_o,
    output logic         bout_o
);

    logic [N:0] borrow;

    always_comb begin
        borrow    = '0;
        diff_o    = '0;
        borrow[0] = bin_i;
        for (int i = 0; i < N; i++) begin
            diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
            borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
        end
        bout_o = borrow[N];
    end

endmodule

// File: rtl/multiword_subtract_sequencer.sv
// Wide a - b - bin computed one WORD-bit chunk per cycle through a shared subtractor
// slice, LSB chunk first, with valid/ready handshakes on operand and result sides.
module multiword_subtract_sequencer
    import multiword_subtract_pkg::*;
#(
    parameter int unsigned WORD  = DEFAULT_WORD,
    parameter int unsigned WORDS = DEFAULT_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD*WORDS-1:0] a,
    input  logic [WORD*WORDS-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD*WORDS-1:0] diff,
    output logic                  bout,
    output logic                  zero,
    output logic                  busy
);

    localparam int unsigned W  = WORD * WORDS;
    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    res_sh_q, res_sh_d;
    logic            borrow_q, borrow_d;
    logic            bout_q, bout_d;
    logic            zero_q, zero_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [WORD-1:0] slice_diff;
    logic            slice_bout;
    logic [W-1:0]    res_shifted;

    ripple_carry_subtractor #(
        .N(WORD)
    ) u_slice (
        .a_i   (a_sh_q[WORD-1:0]),
        .b_i   (b_sh_q[WORD-1:0]),
        .bin_i (borrow_q),
        .diff_o(slice_diff),
        .bout_o(slice_bout)
    );

    // New chunk enters at the MSB end so the LSB chunk ends up lowest after WORDS shifts.
    assign res_shifted = (res_sh_q >> WORD) | (W'(slice_diff) << (W - WORD));

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_sh_d  = res_sh_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> WORD;
                b_sh_d   = b_sh_q >> WORD;
                res_sh_d = res_shifted;
                borrow_d = slice_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WORDS - 1)) begin
                    bout_d  = slice_bout;
                    zero_d  = (res_shifted == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign diff = res_sh_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_multiword_subtract_sequencer.sv
// Scoreboard bench for multiword_subtract_sequencer (WORD=4, WORDS=4): a driver pushes
// expected results from a plain-arithmetic model, a monitor pops them on each output transfer.
module tb_multiword_subtract_sequencer;

    localparam int WORD  = 4;
    localparam int WORDS = 4;
    localparam int W     = WORD * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W+1:0] exp_q[$];
    int xfer_cyc[$];

    multiword_subtract_sequencer #(
        .WORD (WORD),
        .WORDS(WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width unsigned subtraction with one extra bit for the borrow.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        logic [W:0] full;
        full = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
        return {full[W-1:0], full[W], (full[W-1:0] == '0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        output int acc);
        int n;
        n   = 0;
        acc = -1;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(ta, tb_, tbin));
            acc = cyc;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
    endtask

    task automatic wait_valid(output int when);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        when = cyc;
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL valid_timeout: out_valid got 0 expected 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_diff"}, diff, 0);
        chk({tag, "_bout"}, bout, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: diff got %0h expected none", diff);
                end else begin
                    e = exp_q.pop_front();
                    chk("diff", diff, e[W+1:2]);
                    chk("bout", bout, e[1]);
                    chk("zero", zero, e[0]);
                end
                xfer_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int acc, acc2, vt, xlast, seen;
        logic [W-1:0] d0;
        bit done;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic plus latency from accept to first out_valid.
        send(16'h1234, 16'h0235, 1'b0, acc);
        wait_valid(vt);
        chk("latency", vt - acc, WORDS + 1);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Wrap, borrow-in with zero result, borrow-in with equal operands.
        send(16'h0000, 16'h0001, 1'b0, acc);
        send(16'h0005, 16'h0004, 1'b1, acc);
        send(16'hABCD, 16'hABCD, 1'b1, acc);
        send(16'hF000, 16'h0001, 1'b0, acc);
        drain();

        // Backpressure: result held stable, new request waits for the transfer.
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h8000, 16'h7FFF, 1'b0, acc);
        wait_valid(vt);
        d0 = diff;
        fork
            send(16'h0100, 16'h0200, 1'b1, acc2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_diff_stable", diff, d0);
                    chk("bp_in_ready", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        xlast = (xfer_cyc.size() > 0) ? xfer_cyc[xfer_cyc.size() - 1] : 1 << 30;
        chk("accept_after_transfer", acc2 > xlast, 1);
        drain();

        // Reset while cnt==2 aborts the operation.
        send(16'h4321, 16'h1111, 1'b0, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrun");
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("no_result_after_reset", seen, 0);
        send(16'h4321, 16'h1111, 1'b0, acc);
        drain();

        // Back-to-back with the consumer always ready.
        xfer_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), acc);
        end
        drain();
        chk("b2b_count", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("b2b_spacing0", xfer_cyc[1] - xfer_cyc[0], WORDS + 2);
            chk("b2b_spacing1", xfer_cyc[2] - xfer_cyc[1], WORDS + 2);
        end

        // Random operands with random consumer backpressure.
        done = 1'b0;
        fork
            while (!done) begin
                @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), acc);
                end
                drain();
                done = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
